alu_comparator_seq: RTL

- Parametrised, multi-cycle successor to the ALU comparator.
- Compares two XLEN operands MSB-first, CHUNK_W bits per cycle, with optional early exit.
- Covers branch conditions, SLT/SLTU, and new MIN/MAX/MINU/MAXU result modes.
- Sits between operand fetch and branch/writeback logic; valid/ready handshake on both sides replaces the fixed one-cycle dat_ready timing.

---
 rtl/alu_comparator_seq.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_comparator_seq.sv
// Multi-cycle comparator. It compares two operands MSB-first, CHUNK_W bits per cycle,
// and produces branch, set-less-than and min/max results over a valid/ready handshake.
module alu_comparator_seq #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CHUNK_W    = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic            soc_clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] ALU_dat1,
  input  logic [XLEN-1:0] ALU_dat2,
  input  logic [4:0]      Instruction_to_ALU,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            Comparator_con_met,
  output logic [XLEN-1:0] Comparator_out,
  output logic            illegal_op,
  output logic            busy
);

  localparam int unsigned NCHUNK = XLEN / CHUNK_W;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [4:0] OP_BEQ  = 5'd0;
  localparam logic [4:0] OP_BNE  = 5'd1;
  localparam logic [4:0] OP_BLT  = 5'd2;
  localparam logic [4:0] OP_BGE  = 5'd3;
  localparam logic [4:0] OP_BLTU = 5'd4;
  localparam logic [4:0] OP_BGEU = 5'd5;
  localparam logic [4:0] OP_SLT  = 5'd9;
  localparam logic [4:0] OP_SLTU = 5'd10;
  localparam logic [4:0] OP_MIN  = 5'd11;
  localparam logic [4:0] OP_MAX  = 5'd12;
  localparam logic [4:0] OP_MINU = 5'd13;
  localparam logic [4:0] OP_MAXU = 5'd14;

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} state_t;
  typedef enum logic [1:0] {REL_EQ, REL_LT, REL_GT} rel_t;

  state_t             r_state, w_state_nxt;
  logic [XLEN-1:0]    r_a, r_b, w_a_nxt, w_b_nxt;
  logic [4:0]         r_op, w_op_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  rel_t               r_rel, w_rel_nxt, w_rel_upd;
  logic               r_out_valid, w_out_valid_nxt;
  logic               r_con, w_con_nxt;
  logic [XLEN-1:0]    r_out, w_out_nxt;
  logic               r_illegal, w_illegal_nxt;

  logic               w_signed_op, w_legal_op, w_load;
  logic [XLEN-1:0]    w_flip, w_cmp_a, w_cmp_b;
  logic [31:0]        w_shamt;
  logic [CHUNK_W-1:0] w_chunk_a, w_chunk_b;
  logic               w_neq, w_lt, w_last;
  logic               w_res_con;
  logic [XLEN-1:0]    w_res_out;

  // Opcode classification for the latched opcode
  always_comb begin
    w_signed_op = 1'b0;
    w_legal_op  = 1'b1;
    case (r_op)
      OP_BLT, OP_BGE, OP_SLT, OP_MIN, OP_MAX: w_signed_op = 1'b1;
      OP_BEQ, OP_BNE, OP_BLTU, OP_BGEU, OP_SLTU, OP_MINU, OP_MAXU: w_signed_op = 1'b0;
      default: w_legal_op = 1'b0;
    endcase
  end

  // Flipping the sign bit turns a signed compare into an unsigned one
  assign w_flip    = {w_signed_op, {(XLEN-1){1'b0}}};
  assign w_cmp_a   = r_a ^ w_flip;
  assign w_cmp_b   = r_b ^ w_flip;
  assign w_shamt   = 32'(r_idx) * CHUNK_W;
  assign w_chunk_a = CHUNK_W'(w_cmp_a >> w_shamt);
  assign w_chunk_b = CHUNK_W'(w_cmp_b >> w_shamt);
  assign w_neq     = (w_chunk_a != w_chunk_b);
  assign w_lt      = (w_chunk_a < w_chunk_b);

  // The first unequal chunk from the top decides; later chunks never override it
  assign w_rel_upd = ((r_rel == REL_EQ) && w_neq) ? (w_lt ? REL_LT : REL_GT) : r_rel;
  assign w_last    = (r_idx == '0) || (EARLY_EXIT && w_neq);

  // Result selection from the final relation
  always_comb begin
    w_res_con = 1'b0;
    w_res_out = '0;
    case (r_op)
      OP_BEQ:          w_res_con = (w_rel_upd == REL_EQ);
      OP_BNE:          w_res_con = (w_rel_upd != REL_EQ);
      OP_BLT, OP_BLTU: w_res_con = (w_rel_upd == REL_LT);
      OP_BGE, OP_BGEU: w_res_con = (w_rel_upd != REL_LT);
      OP_SLT, OP_SLTU: begin
        w_res_con = (w_rel_upd == REL_LT);
        w_res_out = XLEN'(w_res_con);
      end
      OP_MIN, OP_MINU: begin
        w_res_con = (w_rel_upd == REL_LT);
        w_res_out = w_res_con ? r_a : r_b;
      end
      OP_MAX, OP_MAXU: begin
        w_res_con = (w_rel_upd == REL_GT);
        w_res_out = w_res_con ? r_a : r_b;
      end
      default: w_res_con = 1'b0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_op_nxt        = r_op;
    w_idx_nxt       = r_idx;
    w_rel_nxt       = r_rel;
    w_out_valid_nxt = r_out_valid;
    w_con_nxt       = r_con;
    w_out_nxt       = r_out;
    w_illegal_nxt   = r_illegal;
    w_load          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (in_valid) w_load = 1'b1;
      end
      S_CMP: begin
        // Unsupported opcodes spend their single cycle here so out_valid lands at E0+1
        if (!w_legal_op) begin
          w_state_nxt     = S_DONE;
          w_out_valid_nxt = 1'b1;
          w_con_nxt       = 1'b0;
          w_out_nxt       = '0;
          w_illegal_nxt   = 1'b1;
        end else begin
          w_rel_nxt = w_rel_upd;
          w_idx_nxt = r_idx - IDX_W'(1);
          if (w_last) begin
            w_state_nxt     = S_DONE;
            w_out_valid_nxt = 1'b1;
            w_con_nxt       = w_res_con;
            w_out_nxt       = w_res_out;
            w_illegal_nxt   = 1'b0;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          if (in_valid) w_load = 1'b1;
          else          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_load) begin
      w_state_nxt = S_CMP;
      w_a_nxt     = ALU_dat1;
      w_b_nxt     = ALU_dat2;
      w_op_nxt    = Instruction_to_ALU;
      w_idx_nxt   = IDX_W'(NCHUNK - 1);
      w_rel_nxt   = REL_EQ;
    end
  end

  always_ff @(posedge soc_clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_idx       <= '0;
      r_rel       <= REL_EQ;
      r_out_valid <= 1'b0;
      r_con       <= 1'b0;
      r_out       <= '0;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_op        <= w_op_nxt;
      r_idx       <= w_idx_nxt;
      r_rel       <= w_rel_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_con       <= w_con_nxt;
      r_out       <= w_out_nxt;
      r_illegal   <= w_illegal_nxt;
    end
  end

  assign in_ready           = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign busy               = (r_state != S_IDLE);
  assign out_valid          = r_out_valid;
  assign Comparator_con_met = r_con;
  assign Comparator_out     = r_out;
  assign illegal_op         = r_illegal;

endmodule
